seq_mult_param: RTL and testbench

SEQ_MULT_PARAM -- requirements
Module: seq_mult_param

---
 rtl/seq_mult_param.sv | 116 +++++++++++
 tb/tb_seq_mult_param.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_param.sv
// Sequential shift-and-add multiplier for unsigned or two's-complement operands.
// Each CALC cycle examines one multiplier bit, LSB first. Signed operands are
// reduced to magnitudes at capture, and the product sign is applied on the
// final CALC edge.
module seq_mult_param #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sgn,
    input  logic [WIDTH-1:0]     inp1,
    input  logic [WIDTH-1:0]     inp2,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 rdy,
    output logic                 busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              capture;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     mcand;
    logic [WIDTH-1:0]  mplier;
    logic [PW-1:0]     acc;
    logic              neg;
    logic [WIDTH-1:0]  mag1;
    logic [WIDTH-1:0]  mag2;
    logic [PW-1:0]     acc_sum;
    logic              last;

    // Operand magnitudes and the accumulator value after the current step.
    // The most-negative value maps onto its own bit pattern, i.e. 2^(WIDTH-1).
    always_comb begin
        mag1    = (sgn && inp1[WIDTH-1]) ? (~inp1 + WIDTH'(1)) : inp1;
        mag2    = (sgn && inp2[WIDTH-1]) ? (~inp2 + WIDTH'(1)) : inp2;
        acc_sum = acc + (mplier[0] ? mcand : '0);
        last    = (cnt == CW'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        busy      = 1'b0;
        rdy       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                rdy = 1'b1;
                if (!start) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-and-add steps, and the product register.
    // The multiplicand shifts left and the multiplier right, so bit cnt of the
    // captured multiplier always appears at mplier[0].
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            prod   <= '0;
        end else if (capture) begin
            cnt    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag1};
            mplier <= mag2;
            acc    <= '0;
            neg    <= sgn & (inp1[WIDTH-1] ^ inp2[WIDTH-1]);
        end else if (busy) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last) begin
                prod <= neg ? (~acc_sum + PW'(1)) : acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param at WIDTH=8 and WIDTH=4, using
// random and directed operands checked against an arithmetic reference.
module tb_seq_mult_param;

    logic        clk = 1'b0;
    logic        rst;

    logic        start8, sgn8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;
    logic        rdy8, busy8;

    logic        start4, sgn4;
    logic [3:0]  a4, b4;
    logic [7:0]  prod4;
    logic        rdy4, busy4;

    int n_cmp  = 0;
    int n_fail = 0;

    seq_mult_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sgn(sgn8),
        .inp1(a8), .inp2(b8), .prod(prod8), .rdy(rdy8), .busy(busy8)
    );

    seq_mult_param #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sgn(sgn4),
        .inp1(a4), .inp2(b4), .prod(prod4), .rdy(rdy4), .busy(busy4)
    );

    always #5 clk = ~clk;

    // Reference: interpret operands as signed or unsigned integers, multiply,
    // and keep the low 2*w bits.
    function automatic longint unsigned ref_mul(input longint unsigned a, input longint unsigned b,
                                                input bit s, input int w);
        longint sa;
        longint sb;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[w-1]) sa = sa - (longint'(1) << w);
        if (s && b[w-1]) sb = sb - (longint'(1) << w);
        return longint'(sa * sb) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Launch one 8-bit operation and wait (bounded) for rdy. Optionally scrambles
    // the operand inputs every cycle after capture. Leaves the DUT back in IDLE.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s, input bit scramble,
                        output logic [15:0] p, output int lat, output int bcnt, output logic busy_at_rdy);
        start8 = 1'b1; a8 = a; b8 = b; sgn8 = s;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 0; bcnt = 0;
        while (!rdy8 && lat < 64) begin
            if (busy8) bcnt++;
            if (scramble) begin
                a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        p = prod8;
        busy_at_rdy = busy8;
        @(posedge clk); #1;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                        output logic [7:0] p, output int lat);
        start4 = 1'b1; a4 = a; b4 = b; sgn4 = s;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 0;
        while (!rdy4 && lat < 64) begin
            a4 = 4'($urandom); b4 = 4'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        p = prod4;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        n_cmp++;
        if (prod8 !== 16'h0 || rdy8 !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset8: prod=%h rdy=%b busy=%b required prod=0000 rdy=0 busy=0", prod8, rdy8, busy8);
        end
        n_cmp++;
        if (prod4 !== 8'h0 || rdy4 !== 1'b0 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset4: prod=%h rdy=%b busy=%b required prod=00 rdy=0 busy=0", prod4, rdy4, busy4);
        end
    endtask

    task automatic test_directed;
        logic [7:0]  da [4] = '{8'd10, 8'd255, 8'hFD, 8'h80};
        logic [7:0]  db [4] = '{8'd11, 8'd255, 8'd5,  8'h80};
        logic        ds [4] = '{1'b0,  1'b0,   1'b1,  1'b1};
        logic [15:0] de [4] = '{16'd110, 16'hFE01, 16'hFFF1, 16'h4000};
        logic [15:0] p;
        int lat, bcnt;
        logic bz;
        for (int i = 0; i < 4; i++) begin
            run8(da[i], db[i], ds[i], 1'b0, p, lat, bcnt, bz);
            n_cmp++;
            if (p !== de[i]) begin
                n_fail++;
                $display("FAIL directed_prod[%0d]: got %h required %h", i, p, de[i]);
            end
            n_cmp++;
            if (lat != 8 || bcnt != 8 || bz !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_timing[%0d]: latency=%0d busy_cycles=%0d busy_at_rdy=%b required 8/8/0",
                         i, lat, bcnt, bz);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0]  a, b;
        logic        s;
        logic [15:0] p, e;
        int lat, bcnt;
        logic bz;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
            if (i % 10 == 0) a = 8'h00;
            if (i % 10 == 5) b = 8'h00;
            e = 16'(ref_mul(64'(a), 64'(b), s, 8));
            run8(a, b, s, 1'b1, p, lat, bcnt, bz);
            n_cmp++;
            if (p !== e || lat != 8) begin
                n_fail++;
                $display("FAIL random[%0d] %h*%h sgn=%b: prod=%h latency=%0d required prod=%h latency=8",
                         i, a, b, s, p, lat, e);
            end
        end
    endtask

    task automatic test_idle_hold;
        logic [15:0] p;
        int lat, bcnt;
        logic bz;
        run8(8'd37, 8'd91, 1'b0, 1'b0, p, lat, bcnt, bz);
        for (int i = 0; i < 6; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom);
            @(posedge clk); #1;
            n_cmp++;
            if (prod8 !== 16'd3367 || busy8 !== 1'b0 || rdy8 !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_hold[%0d]: prod=%h busy=%b rdy=%b required prod=%h busy=0 rdy=0",
                         i, prod8, busy8, rdy8, 16'd3367);
            end
        end
    endtask

    task automatic test_handshake;
        int lat;
        start8 = 1'b1; a8 = 8'd7; b8 = 8'd9; sgn8 = 1'b0;
        @(posedge clk); #1;
        lat = 0;
        while (!rdy8 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat != 8 || prod8 !== 16'd63) begin
            n_fail++;
            $display("FAIL hs_first: latency=%0d prod=%h required latency=8 prod=%h", lat, prod8, 16'd63);
        end
        for (int i = 0; i < 5; i++) begin
            a8 = 8'($urandom); b8 = 8'($urandom);
            @(posedge clk); #1;
            n_cmp++;
            if (rdy8 !== 1'b1 || busy8 !== 1'b0 || prod8 !== 16'd63) begin
                n_fail++;
                $display("FAIL hs_hold[%0d]: rdy=%b busy=%b prod=%h required rdy=1 busy=0 prod=%h",
                         i, rdy8, busy8, prod8, 16'd63);
            end
        end
        start8 = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (rdy8 !== 1'b0 || busy8 !== 1'b0 || prod8 !== 16'd63) begin
            n_fail++;
            $display("FAIL hs_release: rdy=%b busy=%b prod=%h required rdy=0 busy=0 prod=%h",
                     rdy8, busy8, prod8, 16'd63);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        logic [15:0] p;
        int lat, bcnt;
        logic bz;
        // Abort during CALC; prod holds 63 from the previous test.
        start8 = 1'b1; a8 = 8'd200; b8 = 8'd3; sgn8 = 1'b0;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (prod8 !== 16'h0 || rdy8 !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_calc: prod=%h rdy=%b busy=%b required 0/0/0", prod8, rdy8, busy8);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (rdy8 || busy8) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_no_rdy: cycles with rdy/busy=%0d required 0", seen);
        end
        // Abort during DONE with start held high.
        start8 = 1'b1; a8 = 8'd12; b8 = 8'd12; sgn8 = 1'b0;
        repeat (12) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (prod8 !== 16'h0 || rdy8 !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done: prod=%h rdy=%b busy=%b required 0/0/0", prod8, rdy8, busy8);
        end
        start8 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        // First capture after release is the first edge with start high.
        run8(8'hF0, 8'h0F, 1'b1, 1'b0, p, lat, bcnt, bz);
        n_cmp++;
        if (p !== 16'hFF10 || lat != 8) begin
            n_fail++;
            $display("FAIL after_reset: prod=%h latency=%0d required prod=ff10 latency=8", p, lat);
        end
    endtask

    task automatic test_width4;
        logic [7:0] p, e;
        logic [3:0] a, b;
        logic s;
        int lat;
        run4(4'd15, 4'd15, 1'b0, p, lat);
        n_cmp++;
        if (p !== 8'd225 || lat != 4) begin
            n_fail++;
            $display("FAIL w4_unsigned: prod=%h latency=%0d required prod=e1 latency=4", p, lat);
        end
        run4(4'h8, 4'd7, 1'b1, p, lat);
        n_cmp++;
        if (p !== 8'hC8 || lat != 4) begin
            n_fail++;
            $display("FAIL w4_signed: prod=%h latency=%0d required prod=c8 latency=4", p, lat);
        end
        for (int i = 0; i < 12; i++) begin
            a = 4'($urandom); b = 4'($urandom); s = 1'($urandom);
            e = 8'(ref_mul(64'(a), 64'(b), s, 4));
            run4(a, b, s, p, lat);
            n_cmp++;
            if (p !== e || lat != 4) begin
                n_fail++;
                $display("FAIL w4_random[%0d] %h*%h sgn=%b: prod=%h latency=%0d required prod=%h latency=4",
                         i, a, b, s, p, lat, e);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; sgn4 = 1'b0; a4 = '0; b4 = '0;
        #12;
        test_reset;
        @(posedge clk); #1;
        rst = 1'b1;
        test_directed;
        test_random;
        test_idle_hold;
        test_handshake;
        test_reset_mid;
        test_width4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
